// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: core writeback, UART write handshake, issue tracking and read ports.
// The master modport is the driving side (core/bench); the slave modport is the register file.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              RegWrite;
    logic [ADDR_W-1:0] rw;
    logic [DATA_W-1:0] write_data;
    logic              UART_write_enable;
    logic [ADDR_W-1:0] uart_rw;
    logic [DATA_W-1:0] uart_data;
    logic              uart_ready;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] op1_sub;
    logic [DATA_W-1:0] op2_sub;
    logic              stall;

    modport master (
        output RegWrite, rw, write_data,
        output UART_write_enable, uart_rw, uart_data,
        output issue_valid, issue_rd, rs, rt,
        input  uart_ready, op1_sub, op2_sub, stall
    );

    modport slave (
        input  RegWrite, rw, write_data,
        input  UART_write_enable, uart_rw, uart_data,
        input  issue_valid, issue_rd, rs, rt,
        output uart_ready, op1_sub, op2_sub, stall
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with busy-bit scoreboard and a one-entry UART write slot that yields to core writes.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle core writeback data onto the read ports.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);
    localparam int   DEPTH   = 2 ** ADDR_W;
    localparam logic ZERO_EN = (ZERO_REG != 32'sd0);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;

    logic              commit_s;
    logic [DEPTH-1:0]  busy_clr_s;
    logic [DEPTH-1:0]  busy_set_s;
    logic              byp1_s;
    logic              byp2_s;
    logic [DATA_W-1:0] op1_s;
    logic [DATA_W-1:0] op2_s;

    // Index 0 is a constant zero register when ZERO_REG is enabled.
    function automatic logic wr_ok(input logic [ADDR_W-1:0] addr);
        return (ZERO_EN == 1'b0) || (addr != {ADDR_W{1'b0}});
    endfunction

    // UART slot FSM: capture in IDLE, commit only on a cycle without a core write.
    always_comb begin
        state_d     = state_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        commit_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.UART_write_enable) begin
                    hold_addr_d = bus.uart_rw;
                    hold_data_d = bus.uart_data;
                    state_d     = ST_HOLD;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!bus.RegWrite) begin
                    commit_s = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next register-array contents; commit and core write never coincide.
    always_comb begin
        regs_d = regs_q;
        if (commit_s && wr_ok(hold_addr_q)) begin
            regs_d[hold_addr_q] = hold_data_q;
        end else begin
            regs_d[hold_addr_q] = regs_q[hold_addr_q];
        end
        if (bus.RegWrite && wr_ok(bus.rw)) begin
            regs_d[bus.rw] = bus.write_data;
        end else begin
            regs_d[bus.rw] = regs_d[bus.rw];
        end
    end

    // Set is applied after clear so a new producer on the same index keeps it busy.
    assign busy_clr_s = bus.RegWrite ? ({{(DEPTH-1){1'b0}}, 1'b1} << bus.rw) : {DEPTH{1'b0}};
    assign busy_set_s = (bus.issue_valid && wr_ok(bus.issue_rd))
                        ? ({{(DEPTH-1){1'b0}}, 1'b1} << bus.issue_rd) : {DEPTH{1'b0}};
    assign busy_d     = (busy_q & ~busy_clr_s) | busy_set_s;

    // State, slot, array and scoreboard registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            hold_addr_q <= {ADDR_W{1'b0}};
            hold_data_q <= {DATA_W{1'b0}};
            regs_q      <= '{default: {DATA_W{1'b0}}};
            busy_q      <= {DEPTH{1'b0}};
        end else begin
            state_q     <= state_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            regs_q      <= regs_d;
            busy_q      <= busy_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign byp1_s = bus.RegWrite && (bus.rs == bus.rw) && wr_ok(bus.rw);
    assign byp2_s = bus.RegWrite && (bus.rt == bus.rw) && wr_ok(bus.rw);
`else
    assign byp1_s = 1'b0;
    assign byp2_s = 1'b0;
`endif

    assign op1_s = byp1_s ? bus.write_data
                 : (wr_ok(bus.rs) ? regs_q[bus.rs] : {DATA_W{1'b0}});
    assign op2_s = byp2_s ? bus.write_data
                 : (wr_ok(bus.rt) ? regs_q[bus.rt] : {DATA_W{1'b0}});

    assign bus.op1_sub    = op1_s;
    assign bus.op2_sub    = op2_s;
    assign bus.stall      = busy_q[bus.rs] | busy_q[bus.rt];
    assign bus.uart_ready = (state_q == ST_IDLE);
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, core write, scoreboard, UART slot arbitration, zero register, bypass.
module tb_regfile_sb;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.RegWrite          = 1'b0;
        bus.rw                = 5'd0;
        bus.write_data        = 32'h0;
        bus.UART_write_enable = 1'b0;
        bus.uart_rw           = 5'd0;
        bus.uart_data         = 32'h0;
        bus.issue_valid       = 1'b0;
        bus.issue_rd          = 5'd0;
        bus.rs                = 5'd0;
        bus.rt                = 5'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        bus.rs = 5'd1;
        bus.rt = 5'd2;
        #2;
        n_cmp++; if (bus.op1_sub !== 32'h0) begin n_fail++; $display("FAIL rst_op1: got %h want %h", bus.op1_sub, 32'h0); end
        n_cmp++; if (bus.op2_sub !== 32'h0) begin n_fail++; $display("FAIL rst_op2: got %h want %h", bus.op2_sub, 32'h0); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", bus.stall); end
        n_cmp++; if (bus.uart_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.uart_ready); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        n_cmp++; if (bus.op1_sub !== 32'h0) begin n_fail++; $display("FAIL run_op1: got %h want %h", bus.op1_sub, 32'h0); end
        n_cmp++; if (bus.uart_ready !== 1'b1) begin n_fail++; $display("FAIL run_ready: got %b want 1", bus.uart_ready); end
    endtask

    task automatic test_core_write();
        bus.RegWrite   = 1'b1;
        bus.rw         = 5'd1;
        bus.write_data = 32'h10101010;
        tick();
        bus.RegWrite = 1'b0;
        bus.rs       = 5'd1;
        #1;
        n_cmp++; if (bus.op1_sub !== 32'h10101010) begin n_fail++; $display("FAIL core_wr: got %h want %h", bus.op1_sub, 32'h10101010); end
    endtask

    task automatic test_busy();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd2;
        tick();
        bus.issue_valid = 1'b0;
        bus.rs = 5'd1;
        bus.rt = 5'd2;
        #1;
        n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL busy_set: got %b want 1", bus.stall); end
        bus.RegWrite   = 1'b1;
        bus.rw         = 5'd2;
        bus.write_data = 32'h22222222;
        tick();
        bus.RegWrite = 1'b0;
        #1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL busy_clr: got %b want 0", bus.stall); end
        // Same index issued and written back on one edge stays busy.
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd6;
        bus.RegWrite    = 1'b1;
        bus.rw          = 5'd6;
        bus.write_data  = 32'h66666666;
        tick();
        bus.issue_valid = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.rs = 5'd6;
        bus.rt = 5'd1;
        #1;
        n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL busy_same_edge: got %b want 1", bus.stall); end
        n_cmp++; if (bus.op1_sub !== 32'h66666666) begin n_fail++; $display("FAIL busy_same_data: got %h want %h", bus.op1_sub, 32'h66666666); end
        bus.RegWrite = 1'b1;
        bus.rw       = 5'd6;
        tick();
        bus.RegWrite = 1'b0;
        #1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL busy_rs_clr: got %b want 0", bus.stall); end
    endtask

    task automatic test_uart_hold();
        bus.UART_write_enable = 1'b1;
        bus.uart_rw           = 5'd3;
        bus.uart_data         = 32'hCAFEF00D;
        bus.RegWrite          = 1'b1;
        bus.rw                = 5'd4;
        bus.write_data        = 32'h44444444;
        bus.rs = 5'd3;
        bus.rt = 5'd4;
        tick();
        bus.UART_write_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (bus.uart_ready !== 1'b0) begin n_fail++; $display("FAIL uart_ready_hold%0d: got %b want 0", i, bus.uart_ready); end
            n_cmp++; if (bus.op1_sub !== 32'h0) begin n_fail++; $display("FAIL uart_reg3_hold%0d: got %h want %h", i, bus.op1_sub, 32'h0); end
            tick();
        end
        bus.RegWrite = 1'b0;
        #1;
        n_cmp++; if (bus.uart_ready !== 1'b0) begin n_fail++; $display("FAIL uart_ready_pre: got %b want 0", bus.uart_ready); end
        tick();
        n_cmp++; if (bus.op1_sub !== 32'hCAFEF00D) begin n_fail++; $display("FAIL uart_commit: got %h want %h", bus.op1_sub, 32'hCAFEF00D); end
        n_cmp++; if (bus.uart_ready !== 1'b1) begin n_fail++; $display("FAIL uart_ready_back: got %b want 1", bus.uart_ready); end
        n_cmp++; if (bus.op2_sub !== 32'h44444444) begin n_fail++; $display("FAIL uart_core_reg4: got %h want %h", bus.op2_sub, 32'h44444444); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL uart_no_busy: got %b want 0", bus.stall); end
    endtask

    task automatic test_zero_reg();
        bus.RegWrite    = 1'b1;
        bus.rw          = 5'd0;
        bus.write_data  = 32'hFFFFFFFF;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        bus.rs = 5'd0;
        bus.rt = 5'd0;
        #1;
        n_cmp++; if (bus.op1_sub !== 32'h0) begin n_fail++; $display("FAIL zero_same_cycle: got %h want %h", bus.op1_sub, 32'h0); end
        tick();
        bus.RegWrite    = 1'b0;
        bus.issue_valid = 1'b0;
        #1;
        n_cmp++; if (bus.op1_sub !== 32'h0) begin n_fail++; $display("FAIL zero_read: got %h want %h", bus.op1_sub, 32'h0); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall: got %b want 0", bus.stall); end
        bus.UART_write_enable = 1'b1;
        bus.uart_rw           = 5'd0;
        bus.uart_data         = 32'hAAAAAAAA;
        tick();
        bus.UART_write_enable = 1'b0;
        tick();
        n_cmp++; if (bus.op1_sub !== 32'h0) begin n_fail++; $display("FAIL zero_uart: got %h want %h", bus.op1_sub, 32'h0); end
    endtask

    task automatic test_bypass();
        bus.RegWrite   = 1'b1;
        bus.rw         = 5'd5;
        bus.write_data = 32'h00000011;
        tick();
        bus.write_data = 32'h00000055;
        bus.rs         = 5'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        n_cmp++; if (bus.op1_sub !== 32'h00000055) begin n_fail++; $display("FAIL bypass_same: got %h want %h", bus.op1_sub, 32'h00000055); end
`else
        n_cmp++; if (bus.op1_sub !== 32'h00000011) begin n_fail++; $display("FAIL bypass_old: got %h want %h", bus.op1_sub, 32'h00000011); end
`endif
        tick();
        bus.RegWrite = 1'b0;
        #1;
        n_cmp++; if (bus.op1_sub !== 32'h00000055) begin n_fail++; $display("FAIL bypass_after: got %h want %h", bus.op1_sub, 32'h00000055); end
    endtask

    task automatic test_reset_hold();
        bus.UART_write_enable = 1'b1;
        bus.uart_rw           = 5'd7;
        bus.uart_data         = 32'h77777777;
        bus.RegWrite          = 1'b1;
        bus.rw                = 5'd8;
        bus.write_data        = 32'h88888888;
        tick();
        bus.UART_write_enable = 1'b0;
        bus.RegWrite          = 1'b0;
        bus.issue_valid       = 1'b1;
        bus.issue_rd          = 5'd9;
        bus.rs = 5'd1;
        bus.rt = 5'd9;
        reset  = 1'b0;
        #2;
        n_cmp++; if (bus.uart_ready !== 1'b1) begin n_fail++; $display("FAIL rsthold_ready: got %b want 1", bus.uart_ready); end
        n_cmp++; if (bus.op1_sub !== 32'h0) begin n_fail++; $display("FAIL rsthold_clear: got %h want %h", bus.op1_sub, 32'h0); end
        bus.issue_valid = 1'b0;
        #1;
        reset = 1'b1;
        bus.RegWrite   = 1'b1;
        bus.rw         = 5'd11;
        bus.write_data = 32'h00000B0B;
        tick();
        bus.RegWrite = 1'b0;
        bus.rs = 5'd11;
        bus.rt = 5'd9;
        #1;
        n_cmp++; if (bus.op1_sub !== 32'h00000B0B) begin n_fail++; $display("FAIL first_write: got %h want %h", bus.op1_sub, 32'h00000B0B); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rsthold_busy: got %b want 0", bus.stall); end
        tick();
        bus.rs = 5'd7;
        #1;
        n_cmp++; if (bus.op1_sub !== 32'h0) begin n_fail++; $display("FAIL rsthold_discard: got %h want %h", bus.op1_sub, 32'h0); end
    endtask

    task automatic test_back_to_back();
        bus.UART_write_enable = 1'b1;
        bus.uart_rw           = 5'd12;
        bus.uart_data         = 32'h99999999;
        tick();
        bus.uart_rw   = 5'd13;
        bus.uart_data = 32'hAAAA5555;
        tick();
        tick();
        bus.UART_write_enable = 1'b0;
        tick();
        bus.rs = 5'd12;
        bus.rt = 5'd13;
        #1;
        n_cmp++; if (bus.op1_sub !== 32'h99999999) begin n_fail++; $display("FAIL b2b_first: got %h want %h", bus.op1_sub, 32'h99999999); end
        n_cmp++; if (bus.op2_sub !== 32'hAAAA5555) begin n_fail++; $display("FAIL b2b_second: got %h want %h", bus.op2_sub, 32'hAAAA5555); end
        n_cmp++; if (bus.uart_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", bus.uart_ready); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_core_write();
        test_busy();
        test_uart_hold();
        test_zero_reg();
        test_bypass();
        test_reset_hold();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning index width; depth is 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-004 The block SHALL have port clk  in  1  meaning the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port reset  in  1  meaning asynchronous, active-low reset; 0 resets, 1 runs.
REQ-006 The block SHALL have port RegWrite  in  1  meaning core writeback strobe.
REQ-007 The block SHALL have port rw  in  ADDR_W  meaning core writeback index.
REQ-008 The block SHALL have port write_data  in  DATA_W  meaning core writeback data.
REQ-009 The block SHALL have port UART_write_enable  in  1  meaning UART write valid.
REQ-010 The block SHALL have port uart_rw  in  ADDR_W  meaning UART write index.
REQ-011 The block SHALL have port uart_data  in  DATA_W  meaning UART write data.
REQ-012 The block SHALL have port uart_ready  out  1  meaning the UART holding slot is empty and the UART write is accepted.
REQ-013 The block SHALL have port issue_valid  in  1  meaning an instruction issued that will write issue_rd.
REQ-014 The block SHALL have port issue_rd  in  ADDR_W  meaning destination index of the issued instruction.
REQ-015 The block SHALL have ports rs and rt  in  ADDR_W  meaning read indices for ports 1 and 2.
REQ-016 The block SHALL have ports op1_sub and op2_sub  out  DATA_W  meaning combinational read data for rs and rt.
REQ-017 The block SHALL have port stall  out  1  meaning rs or rt is marked busy.

Function
REQ-018 The core write SHALL update the register at rw with write_data on the clock edge when RegWrite is 1.
REQ-019 A UART write SHALL be accepted on an edge where UART_write_enable and uart_ready are both 1, and SHALL be captured into a one-entry holding slot (FSM state IDLE -> HOLD).
REQ-020 In HOLD, the slot SHALL commit to the register file on the first edge with RegWrite 0 (HOLD -> IDLE); core writes always win arbitration.
REQ-021 uart_ready SHALL be 1 in IDLE and 0 in HOLD; an accepted write commits no earlier than one cycle after acceptance.
REQ-022 A busy bit per register SHALL be set on an edge with issue_valid for issue_rd, and cleared on an edge with RegWrite for rw.
REQ-023 When issue_valid and RegWrite target the same index on the same edge, the busy bit SHALL end set (the new producer wins).
REQ-024 stall SHALL be the OR of busy[rs] and busy[rt], evaluated combinationally.
REQ-025 When ZERO_REG is 1, reads of index 0 SHALL return 0, writes to index 0 from either port SHALL be discarded, and busy[0] SHALL never set.
REQ-026 A UART commit SHALL not change any busy bit.
REQ-027 A read of an index committed on the same edge SHALL return the pre-edge value before the edge and the new value after it (subject to REQ-031).

Reset
REQ-028 While reset is 0, all registers SHALL be 0, all busy bits 0, the FSM in IDLE, uart_ready 1, and stall 0.
REQ-029 Reset asserted in HOLD SHALL discard the held UART write without committing it.
REQ-030 The first write SHALL be possible on the first rising clk edge after reset returns to 1.

Configuration
REQ-031 With macro REGFILE_BYPASS_EN defined, when RegWrite is 1 and rs or rt equals a nonzero rw (or any rw when ZERO_REG is 0), the matching op output SHALL return write_data in the same cycle; without the macro, reads SHALL return array contents only.

Verification
REQ-032 The bench SHALL cover this scenario: reset 0 then 1; rs=1, rt=2 -> op1_sub=0, op2_sub=0, stall=0, uart_ready=1.
REQ-033 The bench SHALL cover this scenario: RegWrite=1, rw=1, write_data=32'h10101010 for one edge; then rs=1 -> op1_sub=32'h10101010.
REQ-034 The bench SHALL cover this scenario: issue_valid=1, issue_rd=2 for one edge; rt=2 -> stall=1; RegWrite=1, rw=2 for one edge -> stall=0.
REQ-035 The bench SHALL cover this scenario: UART_write_enable=1, uart_rw=3, uart_data=32'hCAFEF00D with RegWrite held 1 (rw=4) for 3 cycles -> uart_ready=0, reg 3 unchanged; RegWrite drops -> reg 3=32'hCAFEF00D next edge and uart_ready=1.
REQ-036 The bench SHALL cover this scenario: RegWrite=1, rw=0, write_data=32'hFFFFFFFF, issue_valid=1, issue_rd=0 -> rs=0 gives 0 and stall=0 (ZERO_REG=1).
REQ-037 The bench SHALL cover this scenario: with REGFILE_BYPASS_EN, RegWrite=1, rw=5, write_data=32'h00000055, rs=5 -> op1_sub=32'h00000055 in the same cycle; without the macro, op1_sub shows the old value until the edge.
